// File: rtl/sobel_window_gen_if.sv
// rtl/sobel_window_gen_if.sv - FIFO pop side and 3x3 window side handshake bundle
interface sobel_window_gen_if;
    logic [16:0]  din;
    logic [9:0]   data_count;
    logic         rd_en;
    logic         out_ready;
    logic         win_valid;
    logic [143:0] win_data;
    logic [9:0]   win_x;
    logic [8:0]   win_y;

    modport master (
        input  din, data_count, out_ready,
        output rd_en, win_valid, win_data, win_x, win_y
    );

    modport slave (
        output din, data_count, out_ready,
        input  rd_en, win_valid, win_data, win_x, win_y
    );
endinterface

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - pops RGB565 pixels from an FWFT FIFO and emits 3x3 neighbourhoods
module sobel_window_gen #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int MIN_LEVEL = 5
) (
    input  logic                clk_w,
    input  logic                rst_n,
    sobel_window_gen_if.master  bus,
    output logic                frame_done,
    output logic                sof_err
);

    localparam int         AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
    localparam logic [8:0] Y_LAST = 9'(IMG_H - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t         state_q, state_d;
    logic [9:0]     x_q, x_d, cx;
    logic [8:0]     y_q, y_d, cy;
    logic           en, accept, store, resync, last_px;
    logic [AW-1:0]  addr;

    logic [15:0]    lb0 [IMG_W];
    logic [15:0]    lb1 [IMG_W];
    logic [15:0]    rd0_q, rd1_q;
    logic           wr1_pend;
    logic [AW-1:0]  wr1_addr;

    logic           s1_v;
    logic [9:0]     s1_x;
    logic [8:0]     s1_y;
    logic [15:0]    s1_pix;

    logic [15:0]    win_q [9];
    logic           win_valid_q;
    logic [9:0]     win_x_q;
    logic [8:0]     win_y_q;

    // rst_n gates the pop so nothing leaves the FIFO while reset is held
    assign en        = !(win_valid_q && !bus.out_ready);
    assign accept    = rst_n && en && (bus.data_count > 10'(MIN_LEVEL));
    assign bus.rd_en = accept;
    assign addr      = cx[AW-1:0];

    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cx      = x_q;
        cy      = y_q;
        store   = 1'b0;
        resync  = 1'b0;
        last_px = 1'b0;
        case (state_q)
            IDLE:    if (accept && bus.din[16]) store = 1'b1;
            STREAM: begin
                if (accept) begin
                    store  = 1'b1;
                    resync = bus.din[16] && ((x_q != 10'd0) || (y_q != 9'd0));
                end
            end
            default: ;
        endcase
        if (store) begin
            if (bus.din[16]) begin
                cx = '0;
                cy = '0;
            end
            state_d = STREAM;
            if (cx == X_LAST) begin
                x_d = '0;
                if (cy == Y_LAST) begin
                    y_d     = '0;
                    last_px = 1'b1;
                    state_d = IDLE;
                end else begin
                    y_d = cy + 9'd1;
                end
            end else begin
                x_d = cx + 10'd1;
                y_d = cy;
            end
        end
    end

    // lb1 takes the old lb0 word one cycle later from the registered read;
    // that address is not read again until a full line has passed
    always_ff @(posedge clk_w) begin
        if (store) begin
            rd0_q     <= lb0[addr];
            rd1_q     <= lb1[addr];
            lb0[addr] <= bus.din[15:0];
        end
        if (wr1_pend) lb1[wr1_addr] <= rd0_q;
    end

    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            wr1_pend   <= 1'b0;
            wr1_addr   <= '0;
            s1_v       <= 1'b0;
            s1_x       <= '0;
            s1_y       <= '0;
            s1_pix     <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            wr1_pend   <= store;
            frame_done <= last_px;
            sof_err    <= resync;
            if (store) wr1_addr <= addr;
            if (en) begin
                s1_v <= store;
                if (store) begin
                    s1_x   <= cx;
                    s1_y   <= cy;
                    s1_pix <= bus.din[15:0];
                end
            end
        end
    end

    always_ff @(posedge clk_w or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
            win_x_q     <= '0;
            win_y_q     <= '0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else if (en) begin
            win_valid_q <= s1_v && (s1_x >= 10'd2) && (s1_y >= 9'd2);
            if (s1_v) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= rd1_q;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= rd0_q;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= s1_pix;
                if ((s1_x >= 10'd2) && (s1_y >= 9'd2)) begin
                    win_x_q <= s1_x - 10'd1;
                    win_y_q <= s1_y - 9'd1;
                end
            end
        end
    end

    assign bus.win_valid = win_valid_q;
    assign bus.win_x     = win_x_q;
    assign bus.win_y     = win_y_q;
    assign bus.win_data  = {win_q[0], win_q[1], win_q[2],
                            win_q[3], win_q[4], win_q[5],
                            win_q[6], win_q[7], win_q[8]};

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - randomized scoreboard bench for sobel_window_gen on an 8x6 image
module tb_sobel_window_gen;
    localparam int W = 8;
    localparam int H = 6;

    logic clk_w = 1'b0;
    logic rst_n;
    logic frame_done, sof_err;

    sobel_window_gen_if bus();

    sobel_window_gen #(.IMG_W(W), .IMG_H(H), .MIN_LEVEL(5)) dut (
        .clk_w      (clk_w),
        .rst_n      (rst_n),
        .bus        (bus),
        .frame_done (frame_done),
        .sof_err    (sof_err)
    );

    always #5 clk_w = ~clk_w;

    typedef struct {
        logic [143:0] data;
        logic [9:0]   x;
        logic [8:0]   y;
    } win_t;

    win_t         exp_q[$];
    logic [16:0]  fifo_q[$];
    logic [15:0]  img [H][W];
    bit           m_in_frame;
    int           m_p;
    int           exp_fd, exp_se, got_fd, got_se, win_cnt, pops, stall_seen;
    int           n_checks, n_pass;
    int           dc_fixed = 20;
    bit           rdy_rand, dc_rand, cap_first;
    int           stall_cnt;
    logic [143:0] first_data, ref1;
    int           first_x, first_y, last_x, last_y;

    function automatic void chk(bit ok, string name, int act, int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void chk_w(bit ok, string name, logic [143:0] act, logic [143:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Reference: keep the frame as a 2-D image and cut windows out of it
    function automatic void model_accept(logic [16:0] w);
        int x, y;
        win_t e;
        if (w[16]) begin
            if (m_in_frame && m_p != 0) exp_se++;
            m_in_frame = 1;
            m_p = 0;
        end
        if (!m_in_frame) return;
        x = m_p % W;
        y = m_p / W;
        img[y][x] = w[15:0];
        if (x >= 2 && y >= 2) begin
            e.data = '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.data = {e.data[127:0], img[y-2+r][x-2+c]};
            e.x = 10'(x - 1);
            e.y = 9'(y - 1);
            exp_q.push_back(e);
        end
        m_p++;
        if (m_p == W * H) begin
            exp_fd++;
            m_in_frame = 0;
        end
    endfunction

    task automatic step();
        logic [16:0] w;
        @(negedge clk_w);
        if (fifo_q.size() == 0) begin
            bus.din        = '0;
            bus.data_count = '0;
        end else begin
            bus.din        = fifo_q[0];
            bus.data_count = dc_rand ? (($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 5))
                                                                     : 10'($urandom_range(6, 40)))
                                     : 10'(dc_fixed);
        end
        if (stall_cnt > 0) begin
            bus.out_ready = 1'b0;
            stall_cnt--;
        end else begin
            bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        #4;
        if (bus.rd_en === 1'b1) begin
            w = fifo_q.pop_front();
            pops++;
            model_accept(w);
        end
    endtask

    task automatic push_frame(bit ramp);
        for (int i = 0; i < W * H; i++)
            fifo_q.push_back({(i == 0), ramp ? 16'(i) : 16'($urandom)});
    endtask

    task automatic push_junk(int n);
        for (int i = 0; i < n; i++) fifo_q.push_back({1'b0, 16'($urandom)});
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        chk(fifo_q.size() == 0 && exp_q.size() == 0, name,
            fifo_q.size() + exp_q.size(), 0);
        repeat (3) step();
    endtask

    task automatic run_to(int k, string name);
        int n = 0;
        while (!(m_in_frame && m_p >= k) && n < 500) begin
            step();
            n++;
        end
        chk(n < 500, name, n, 500);
    endtask

    win_t         mon_e;
    bit           hold_prev;
    logic [143:0] hold_d;
    logic [9:0]   hold_x;
    logic [8:0]   hold_y;

    always begin
        @(negedge clk_w);
        #3;
        if (!rst_n) begin
            hold_prev = 0;
        end else begin
            if (frame_done) got_fd++;
            if (sof_err) got_se++;
            if (hold_prev)
                chk_w(bus.win_valid && bus.win_data == hold_d && bus.win_x == hold_x && bus.win_y == hold_y,
                      "stall_hold", bus.win_data, hold_d);
            hold_prev = 0;
            if (bus.win_valid && !bus.out_ready) begin
                stall_seen++;
                chk(bus.rd_en == 1'b0, "stall_rd_en", int'(bus.rd_en), 0);
                hold_prev = 1;
                hold_d = bus.win_data;
                hold_x = bus.win_x;
                hold_y = bus.win_y;
            end
            if (bus.win_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_window", int'(bus.win_x) * 1000 + int'(bus.win_y), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk_w(bus.win_data == mon_e.data, "win_data", bus.win_data, mon_e.data);
                    chk(bus.win_x == mon_e.x && bus.win_y == mon_e.y, "win_centre",
                        int'(bus.win_x) * 1000 + int'(bus.win_y), int'(mon_e.x) * 1000 + int'(mon_e.y));
                end
                win_cnt++;
                if (cap_first) begin
                    first_data = bus.win_data;
                    first_x    = int'(bus.win_x);
                    first_y    = int'(bus.win_y);
                    cap_first  = 0;
                end
                last_x = int'(bus.win_x);
                last_y = int'(bus.win_y);
            end
        end
    end

    initial begin
        int w0, f0, s0, p0, st0;
        bit wv_before;
        ref1 = {16'd0, 16'd1, 16'd2, 16'd8, 16'd9, 16'd10, 16'd16, 16'd17, 16'd18};

        rst_n          = 1'b0;
        bus.din        = {1'b1, 16'h1234};
        bus.data_count = 10'd20;
        bus.out_ready  = 1'b1;
        repeat (3) @(negedge clk_w);
        #1;
        chk(bus.win_valid == 1'b0, "reset_win_valid", int'(bus.win_valid), 0);
        chk_w(bus.win_data == '0, "reset_win_data", bus.win_data, '0);
        chk(bus.win_x == 10'd0 && bus.win_y == 9'd0, "reset_win_xy",
            int'(bus.win_x) * 1000 + int'(bus.win_y), 0);
        chk(frame_done == 1'b0, "reset_frame_done", int'(frame_done), 0);
        chk(sof_err == 1'b0, "reset_sof_err", int'(sof_err), 0);
        chk(bus.rd_en == 1'b0, "reset_rd_en", int'(bus.rd_en), 0);
        bus.data_count = '0;
        @(negedge clk_w);
        rst_n = 1'b1;

        // 1: ramp frame
        w0 = win_cnt; f0 = got_fd; cap_first = 1;
        push_frame(1);
        drain("t1_drain");
        chk(win_cnt - w0 == 24, "t1_window_count", win_cnt - w0, 24);
        chk(got_fd - f0 == 1, "t1_frame_done", got_fd - f0, 1);
        chk(first_x == 1 && first_y == 1, "t1_first_centre", first_x * 1000 + first_y, 1001);
        chk_w(first_data == ref1, "t1_first_data", first_data, ref1);
        chk(last_x == 6 && last_y == 4, "t1_last_centre", last_x * 1000 + last_y, 6004);

        // 2: junk before SOF
        w0 = win_cnt; f0 = got_fd; p0 = pops;
        push_junk(5);
        push_frame(1);
        drain("t2_drain");
        chk(pops - p0 == 53, "t2_pops", pops - p0, 53);
        chk(win_cnt - w0 == 24, "t2_window_count", win_cnt - w0, 24);
        chk(got_fd - f0 == 1, "t2_frame_done", got_fd - f0, 1);

        // 3: downstream stall mid row 3
        w0 = win_cnt; st0 = stall_seen;
        push_frame(0);
        run_to(3 * W + 5, "t3_reach_row3");
        p0 = pops;
        stall_cnt = 10;
        repeat (10) step();
        chk(pops == p0, "t3_no_pop_in_stall", pops - p0, 0);
        chk(stall_seen - st0 == 10, "t3_stall_cycles", stall_seen - st0, 10);
        drain("t3_drain");
        chk(win_cnt - w0 == 24, "t3_window_count", win_cnt - w0, 24);

        // 4: FIFO level threshold, then random level and ready
        w0 = win_cnt; f0 = got_fd;
        push_frame(0);
        dc_fixed = 5;
        p0 = pops;
        repeat (20) step();
        chk(pops == p0, "t4_no_pop_at_min", pops - p0, 0);
        dc_fixed = 6;
        step();
        chk(pops == p0 + 1, "t4_pop_above_min", pops - p0, 1);
        dc_fixed = 20;
        rdy_rand = 1; dc_rand = 1;
        drain("t4_drain");
        chk(win_cnt - w0 == 24, "t4_window_count", win_cnt - w0, 24);
        chk(got_fd - f0 == 1, "t4_frame_done", got_fd - f0, 1);

        // 5: SOF injected at (3,2)
        w0 = win_cnt; f0 = got_fd; s0 = got_se;
        for (int i = 0; i < 2 * W + 3; i++) fifo_q.push_back({(i == 0), 16'($urandom)});
        push_frame(0);
        drain("t5_drain");
        rdy_rand = 0; dc_rand = 0;
        chk(got_se - s0 == 1, "t5_sof_err", got_se - s0, 1);
        chk(win_cnt - w0 == 25, "t5_window_count", win_cnt - w0, 25);
        chk(got_fd - f0 == 1, "t5_frame_done", got_fd - f0, 1);

        // 6: asynchronous reset at (5,3)
        push_frame(0);
        run_to(3 * W + 6, "t6_reach_5_3");
        @(negedge clk_w);
        wv_before = bus.win_valid;
        #1 rst_n = 1'b0;
        #1;
        chk(wv_before == 1'b1, "t6_valid_before_reset", int'(wv_before), 1);
        chk(bus.win_valid == 1'b0, "t6_async_win_valid", int'(bus.win_valid), 0);
        chk_w(bus.win_data == '0, "t6_async_win_data", bus.win_data, '0);
        chk(bus.rd_en == 1'b0, "t6_rd_en_in_reset", int'(bus.rd_en), 0);
        exp_q.delete();
        m_in_frame = 0;
        p0 = pops;
        repeat (3) step();
        chk(pops == p0, "t6_no_pop_in_reset", pops - p0, 0);
        bus.data_count = '0;
        @(negedge clk_w);
        rst_n = 1'b1;
        w0 = win_cnt; f0 = got_fd; cap_first = 1;
        push_junk(4);
        push_frame(1);
        drain("t6_drain");
        chk(win_cnt - w0 == 24, "t6_window_count", win_cnt - w0, 24);
        chk(got_fd - f0 == 1, "t6_frame_done", got_fd - f0, 1);
        chk(first_x == 1 && first_y == 1, "t6_first_centre", first_x * 1000 + first_y, 1001);
        chk_w(first_data == ref1, "t6_first_data", first_data, ref1);

        chk(exp_q.size() == 0, "final_scoreboard_empty", exp_q.size(), 0);
        chk(got_fd == exp_fd, "final_frame_done_total", got_fd, exp_fd);
        chk(got_se == exp_se, "final_sof_err_total", got_se, exp_se);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
